parking_slot_monitor: RTL and testbench

//  Downstream consumer and scheduler for the HC-SR04 front end (40 MHz). Periodically

---
 rtl/parking_pkg.sv | 31 +++
 rtl/parking_slot_monitor_if.sv | 28 ++
 rtl/parking_slot_monitor_seq_divider.sv | 76 +++++++
 rtl/parking_slot_monitor.sv | 218 +++++++++++++++++++++
 tb/tb_parking_slot_monitor.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/parking_pkg.sv
// Shared constants, FSM encoding and helpers for the parking slot monitor.
//  CLK_HZ        system clock frequency
//  CYCLES_PER_CM raw echo cycles per centimetre (58 us at 40 MHz)
//  DIST_W        converted distance width; DIST_MAX is its saturation value
//  RAW_W/DIV_W   dividend (raw echo count) and divisor widths
package parking_pkg;

    localparam int unsigned CLK_HZ        = 40_000_000;
    localparam logic [11:0] CYCLES_PER_CM = 12'd2320;
    localparam int unsigned DIST_W        = 10;
    localparam int unsigned RAW_W         = 22;
    localparam int unsigned DIV_W         = 12;

    localparam logic [DIST_W-1:0] DIST_MAX = '1;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StArmed,
        StBusy,
        StDivide,
        StEval,
        StAbort
    } state_e;

    // Increment that sticks at max.
    function automatic logic [2:0] sat_inc(input logic [2:0] val, input logic [2:0] max);
        return (val >= max) ? max : val + 3'd1;
    endfunction

endpackage

// File: rtl/parking_slot_monitor_if.sv
// Handshake between the monitor (master) and the HC-SR04 front end (slave).
//  sns_measure      one-cycle measurement request       (master -> slave)
//  sns_rst          active-high sensor reset            (master -> slave)
//  sns_ready        sensor idle / result available      (slave -> master)
//  sns_distance_raw echo count, stable while sns_ready  (slave -> master)
interface parking_slot_monitor_if;
    import parking_pkg::*;

    logic             sns_measure;
    logic             sns_rst;
    logic             sns_ready;
    logic [RAW_W-1:0] sns_distance_raw;

    modport master (
        output sns_measure,
        output sns_rst,
        input  sns_ready,
        input  sns_distance_raw
    );

    modport slave (
        input  sns_measure,
        input  sns_rst,
        output sns_ready,
        output sns_distance_raw
    );

endinterface

// File: rtl/parking_slot_monitor_seq_divider.sv
// Iterative restoring divider, one quotient bit per clock.
//  clk, rst_n  clock, async active-low reset
//  start       load dividend and begin (one cycle)
//  dividend    RAW_W-bit numerator, sampled on the start edge
//  divisor     DIV_W-bit denominator, must be held constant during a division
//  quotient    truncated result; valid from done onwards until the next start
//  done        one-cycle pulse, RAW_W clocks after the start edge
module seq_divider
    import parking_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [RAW_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic [RAW_W-1:0] quotient,
    output logic             done
);

    logic [RAW_W-1:0] quo_q, quo_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Partial remainder shifted left with the next dividend bit; the remainder is always
    // below the divisor, so DIV_W+1 bits hold the trial value.
    logic [DIV_W:0] trial;
    logic           fits;

    assign trial = {rem_q, quo_q[RAW_W-1]};
    assign fits  = trial >= {1'b0, divisor};

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Dividend bits shift out of the top of quo_q as quotient bits shift in.
            rem_d = fits ? DIV_W'(trial - {1'b0, divisor}) : trial[DIV_W-1:0];
            quo_d = {quo_q[RAW_W-2:0], fits};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(RAW_W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/parking_slot_monitor.sv
// Parking slot monitor: schedules HC-SR04 measurements, converts the echo count to cm,
// and derives slot occupancy with confirm counting and a hysteresis dead band.
//  clk, rst_n      40 MHz clock, async active-low reset
//  enable          permit new launches (an in-flight measurement always completes)
//  sns             sensor handshake (measure/reset requests, ready/raw result)
//  distance_cm     last converted distance, saturating at DIST_MAX
//  distance_valid  one-cycle strobe when distance_cm updates
//  occupied        confirmed occupancy level
//  car_entry/exit  one-cycle pulses on occupied rising/falling
//  sensor_fault    raised after FAULT_N consecutive echo timeouts
module parking_slot_monitor
    import parking_pkg::*;
#(
    parameter logic [23:0]       PERIOD_CYC  = 24'd2400000,
    parameter logic [23:0]       TIMEOUT_CYC = 24'd1520000,
    parameter logic [DIST_W-1:0] ENTRY_CM    = 10'd30,
    parameter logic [DIST_W-1:0] EXIT_CM     = 10'd40,
    parameter logic [2:0]        CONFIRM_N   = 3'd3,
    parameter logic [2:0]        FAULT_N     = 3'd4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    parking_slot_monitor_if.master sns,
    output logic [DIST_W-1:0]      distance_cm,
    output logic                   distance_valid,
    output logic                   occupied,
    output logic                   car_entry,
    output logic                   car_exit,
    output logic                   sensor_fault
);

    state_e            state_q, state_d;
    logic [23:0]       period_cnt_q, period_cnt_d;
    logic [23:0]       to_cnt_q, to_cnt_d;
    logic              first_q, first_d;
    logic              abort_cnt_q, abort_cnt_d;
    logic [2:0]        timeout_cnt_q, timeout_cnt_d;
    logic [2:0]        near_cnt_q, near_cnt_d;
    logic [2:0]        far_cnt_q, far_cnt_d;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic              valid_q, valid_d;
    logic              occ_q, occ_d;
    logic              entry_q, entry_d;
    logic              exit_q, exit_d;
    logic              fault_q, fault_d;

    logic              div_start;
    logic              div_done;
    logic [RAW_W-1:0]  div_quotient;
    logic [DIST_W-1:0] dist_sat;
    logic              is_near;
    logic              is_far;
    logic              to_hit;
    logic [2:0]        timeout_inc;

    // Raw count is latched by the divider itself on the start edge.
    seq_divider u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (sns.sns_distance_raw),
        .divisor  (CYCLES_PER_CM),
        .quotient (div_quotient),
        .done     (div_done)
    );

    // to_cnt counts from the launch cycle, so this fires TIMEOUT_CYC clocks after it.
    assign to_hit      = to_cnt_q == TIMEOUT_CYC - 24'd1;
    assign div_start   = (state_q == StBusy) && !to_hit && sns.sns_ready;
    assign dist_sat    = (div_quotient > RAW_W'(DIST_MAX)) ? DIST_MAX
                                                           : div_quotient[DIST_W-1:0];
    assign is_near     = dist_sat < ENTRY_CM;
    assign is_far      = dist_sat > EXIT_CM;
    assign timeout_inc = sat_inc(timeout_cnt_q, 3'd7);

    always_comb begin
        state_d       = state_q;
        period_cnt_d  = (period_cnt_q < PERIOD_CYC - 24'd1) ? period_cnt_q + 24'd1
                                                            : period_cnt_q;
        to_cnt_d      = to_cnt_q;
        first_d       = first_q;
        abort_cnt_d   = abort_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        near_cnt_d    = near_cnt_q;
        far_cnt_d     = far_cnt_q;
        dist_d        = dist_q;
        valid_d       = 1'b0;
        occ_d         = occ_q;
        entry_d       = 1'b0;
        exit_d        = 1'b0;
        fault_d       = fault_q;

        unique case (state_q)
            StIdle: begin
                if (enable && sns.sns_ready &&
                    (first_q || period_cnt_q >= PERIOD_CYC - 24'd1)) begin
                    // Counters clear on entry so the LAUNCH cycle is count 0.
                    state_d      = StLaunch;
                    period_cnt_d = '0;
                    to_cnt_d     = '0;
                    first_d      = 1'b0;
                end
            end
            StLaunch: begin
                state_d  = StArmed;
                to_cnt_d = to_cnt_q + 24'd1;
            end
            StArmed: begin
                to_cnt_d = to_cnt_q + 24'd1;
                if (to_hit) begin
                    state_d     = StAbort;
                    abort_cnt_d = 1'b0;
                end else if (!sns.sns_ready) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                to_cnt_d = to_cnt_q + 24'd1;
                if (to_hit) begin
                    state_d     = StAbort;
                    abort_cnt_d = 1'b0;
                end else if (sns.sns_ready) begin
                    state_d = StDivide;
                end
            end
            StDivide: begin
                if (div_done) begin
                    state_d = StEval;
                end
            end
            StEval: begin
                state_d       = StIdle;
                dist_d        = dist_sat;
                valid_d       = 1'b1;
                timeout_cnt_d = '0;
                fault_d       = 1'b0;
                if (is_near) begin
                    near_cnt_d = sat_inc(near_cnt_q, CONFIRM_N);
                    far_cnt_d  = '0;
                end else if (is_far) begin
                    far_cnt_d  = sat_inc(far_cnt_q, CONFIRM_N);
                    near_cnt_d = '0;
                end else begin
                    near_cnt_d = '0;
                    far_cnt_d  = '0;
                end
                // Occupancy decisions use the fault level from before this sample.
                if (!fault_q && !occ_q && near_cnt_d == CONFIRM_N) begin
                    occ_d      = 1'b1;
                    entry_d    = 1'b1;
                    near_cnt_d = '0;
                end
                if (!fault_q && occ_q && far_cnt_d == CONFIRM_N) begin
                    occ_d     = 1'b0;
                    exit_d    = 1'b1;
                    far_cnt_d = '0;
                end
            end
            StAbort: begin
                if (!abort_cnt_q) begin
                    abort_cnt_d   = 1'b1;
                    timeout_cnt_d = timeout_inc;
                    if (timeout_inc >= FAULT_N) begin
                        fault_d = 1'b1;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            period_cnt_q  <= '0;
            to_cnt_q      <= '0;
            first_q       <= 1'b1;
            abort_cnt_q   <= 1'b0;
            timeout_cnt_q <= '0;
            near_cnt_q    <= '0;
            far_cnt_q     <= '0;
            dist_q        <= '0;
            valid_q       <= 1'b0;
            occ_q         <= 1'b0;
            entry_q       <= 1'b0;
            exit_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_cnt_q  <= period_cnt_d;
            to_cnt_q      <= to_cnt_d;
            first_q       <= first_d;
            abort_cnt_q   <= abort_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            near_cnt_q    <= near_cnt_d;
            far_cnt_q     <= far_cnt_d;
            dist_q        <= dist_d;
            valid_q       <= valid_d;
            occ_q         <= occ_d;
            entry_q       <= entry_d;
            exit_q        <= exit_d;
            fault_q       <= fault_d;
        end
    end

    assign sns.sns_measure = state_q == StLaunch;
    assign sns.sns_rst     = state_q == StAbort;
    assign distance_cm     = dist_q;
    assign distance_valid  = valid_q;
    assign occupied        = occ_q;
    assign car_entry       = entry_q;
    assign car_exit        = exit_q;
    assign sensor_fault    = fault_q;

endmodule

// File: tb/tb_parking_slot_monitor.sv
// Directed bench for parking_slot_monitor with shortened period/timeout.
module tb_parking_slot_monitor;
    import parking_pkg::*;

    localparam logic [23:0] PERIOD = 24'd300;
    localparam logic [23:0] TMO    = 24'd150;
    // Ready rises at a negedge, the next posedge latches; valid rises 24 posedges later and
    // is first seen on the 25th negedge after ready rose.
    localparam int LAT_NEG = 25;
    localparam int NVEC    = 30;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [9:0]  distance_cm;
    logic        distance_valid;
    logic        occupied;
    logic        car_entry;
    logic        car_exit;
    logic        sensor_fault;

    parking_slot_monitor_if ifc ();

    parking_slot_monitor #(
        .PERIOD_CYC  (PERIOD),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .sns            (ifc),
        .distance_cm    (distance_cm),
        .distance_valid (distance_valid),
        .occupied       (occupied),
        .car_entry      (car_entry),
        .car_exit       (car_exit),
        .sensor_fault   (sensor_fault)
    );

    typedef struct packed {
        logic [21:0] raw;
        logic [9:0]  cm;
        logic        occ;
        logic        car_in;
        logic        car_out;
    } vec_t;

    vec_t   vecs [NVEC];
    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_launch(output bit ok, output longint at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < int'(PERIOD) + 50; i++) begin
            @(negedge clk);
            if (ifc.sns_measure) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    // Sensor model: drop ready for a short echo, present raw, then wait for the strobe.
    task automatic echo(input logic [21:0] raw, output int lat);
        ifc.sns_ready = 1'b0;
        repeat (5) @(negedge clk);
        ifc.sns_distance_raw = raw;
        ifc.sns_ready        = 1'b1;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (distance_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        bit     ok;
        longint at;
        longint prev_at;
        longint rel;
        int     lat;
        int     rst_first;
        int     rst_len;
        int     nvalid;
        int     nlaunch;

        // raw, cm, occupied, car_entry, car_exit at each strobe
        vecs[0]  = {22'd46400,   10'd20,   1'b0, 1'b0, 1'b0};
        vecs[1]  = {22'd46400,   10'd20,   1'b0, 1'b0, 1'b0};
        vecs[2]  = {22'd46400,   10'd20,   1'b1, 1'b1, 1'b0};
        vecs[3]  = {22'd81200,   10'd35,   1'b1, 1'b0, 1'b0};
        vecs[4]  = {22'd81200,   10'd35,   1'b1, 1'b0, 1'b0};
        vecs[5]  = {22'd81200,   10'd35,   1'b1, 1'b0, 1'b0};
        vecs[6]  = {22'd81200,   10'd35,   1'b1, 1'b0, 1'b0};
        vecs[7]  = {22'd81200,   10'd35,   1'b1, 1'b0, 1'b0};
        vecs[8]  = {22'd116000,  10'd50,   1'b1, 1'b0, 1'b0};
        vecs[9]  = {22'd116000,  10'd50,   1'b1, 1'b0, 1'b0};
        vecs[10] = {22'd116000,  10'd50,   1'b0, 1'b0, 1'b1};
        vecs[11] = {22'd46400,   10'd20,   1'b0, 1'b0, 1'b0};
        vecs[12] = {22'd46400,   10'd20,   1'b0, 1'b0, 1'b0};
        vecs[13] = {22'd81200,   10'd35,   1'b0, 1'b0, 1'b0};
        vecs[14] = {22'd46400,   10'd20,   1'b0, 1'b0, 1'b0};
        vecs[15] = {22'd46400,   10'd20,   1'b0, 1'b0, 1'b0};
        vecs[16] = {22'd46400,   10'd20,   1'b1, 1'b1, 1'b0};
        vecs[17] = {22'd92800,   10'd40,   1'b1, 1'b0, 1'b0};
        vecs[18] = {22'd92801,   10'd40,   1'b1, 1'b0, 1'b0};
        vecs[19] = {22'd95120,   10'd41,   1'b1, 1'b0, 1'b0};
        vecs[20] = {22'd95120,   10'd41,   1'b1, 1'b0, 1'b0};
        vecs[21] = {22'd92800,   10'd40,   1'b1, 1'b0, 1'b0};
        vecs[22] = {22'd116000,  10'd50,   1'b1, 1'b0, 1'b0};
        vecs[23] = {22'd116000,  10'd50,   1'b1, 1'b0, 1'b0};
        vecs[24] = {22'd116000,  10'd50,   1'b0, 1'b0, 1'b1};
        vecs[25] = {22'd69600,   10'd30,   1'b0, 1'b0, 1'b0};
        vecs[26] = {22'd69599,   10'd29,   1'b0, 1'b0, 1'b0};
        vecs[27] = {22'd0,       10'd0,    1'b0, 1'b0, 1'b0};
        vecs[28] = {22'd0,       10'd0,    1'b1, 1'b1, 1'b0};
        vecs[29] = {22'd4194303, 10'd1023, 1'b1, 1'b0, 1'b0};

        rst_n                = 1'b0;
        enable               = 1'b0;
        ifc.sns_ready        = 1'b1;
        ifc.sns_distance_raw = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({distance_cm, distance_valid, occupied, car_entry, car_exit,
                                    sensor_fault, ifc.sns_measure, ifc.sns_rst}), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        rel    = cyc;

        // Table: conversion, confirm counting, hysteresis, boundaries, latency and cadence.
        prev_at = 0;
        for (int i = 0; i < NVEC; i++) begin
            wait_launch(ok, at);
            check($sformatf("v%0d_launch_seen", i), 32'(ok), 32'd1);
            if (ok) begin
                if (i == 0) check("first_launch_immediate", 32'(at - rel), 32'd1);
                else check($sformatf("v%0d_launch_period", i), 32'(at - prev_at), 32'(PERIOD));
                prev_at = at;
                echo(vecs[i].raw, lat);
                check($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT_NEG));
                check($sformatf("v%0d_cm", i), 32'(distance_cm), 32'(vecs[i].cm));
                check($sformatf("v%0d_occupied", i), 32'(occupied), 32'(vecs[i].occ));
                check($sformatf("v%0d_entry", i), 32'(car_entry), 32'(vecs[i].car_in));
                check($sformatf("v%0d_exit", i), 32'(car_exit), 32'(vecs[i].car_out));
            end
        end

        // Sensor never drops ready: 2-cycle sns_rst at TIMEOUT_CYC, fault on the 4th.
        for (int t = 1; t <= 4; t++) begin
            wait_launch(ok, at);
            check($sformatf("to%0d_launch_seen", t), 32'(ok), 32'd1);
            rst_first = -1;
            rst_len   = 0;
            nvalid    = 0;
            for (int k = 1; k <= int'(TMO) + 5; k++) begin
                @(negedge clk);
                if (ifc.sns_rst) begin
                    if (rst_first < 0) rst_first = k;
                    rst_len++;
                end
                if (distance_valid) nvalid++;
            end
            check($sformatf("to%0d_rst_start", t), 32'(rst_first), 32'(TMO));
            check($sformatf("to%0d_rst_len", t), 32'(rst_len), 32'd2);
            check($sformatf("to%0d_no_valid", t), 32'(nvalid), 32'd0);
            check($sformatf("to%0d_fault", t), 32'(sensor_fault), 32'(t == 4));
        end
        wait_launch(ok, at);
        check("recover_launch_seen", 32'(ok), 32'd1);
        echo(22'd116000, lat);
        check("recover_latency", 32'(lat), 32'(LAT_NEG));
        check("recover_fault", 32'(sensor_fault), 32'd0);
        check("recover_cm", 32'(distance_cm), 32'd50);
        check("recover_occupied", 32'(occupied), 32'd1);

        // enable drops mid-measurement: that one completes, nothing new launches.
        wait_launch(ok, at);
        check("en_launch_seen", 32'(ok), 32'd1);
        enable = 1'b0;
        echo(22'd46400, lat);
        check("en_inflight_done", 32'(lat), 32'(LAT_NEG));
        check("en_inflight_cm", 32'(distance_cm), 32'd20);
        nlaunch = 0;
        for (int k = 0; k < 2 * int'(PERIOD) + 100; k++) begin
            @(negedge clk);
            if (ifc.sns_measure) nlaunch++;
        end
        check("en_no_launch", 32'(nlaunch), 32'd0);
        enable = 1'b1;

        // Reset in the middle of a division.
        wait_launch(ok, at);
        check("rst_launch_seen", 32'(ok), 32'd1);
        ifc.sns_ready = 1'b0;
        repeat (5) @(negedge clk);
        ifc.sns_distance_raw = 22'd46400;
        ifc.sns_ready        = 1'b1;
        repeat (10) @(negedge clk);
        check("pre_reset_occupied", 32'(occupied), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_divide_reset", 32'({distance_cm, distance_valid, occupied, car_entry,
                                       car_exit, sensor_fault, ifc.sns_measure,
                                       ifc.sns_rst}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
        wait_launch(ok, at);
        check("post_reset_launch_seen", 32'(ok), 32'd1);
        check("post_reset_launch_immediate", 32'(at - rel), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
